uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requester ports; legal values are 2 to 8.
REQ-002 SHALL have parameter GAP_CYCLES, default 16, meaning the idle clocks inserted after each tx_done before the next grant; legal values are 0 to 65535.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 200000, meaning the number of clocks to wait for tx_done before abort; this parameter is used only under UART_ARB_TIMEOUT_EN.
REQ-004 SHALL have port: clk  in  1  system clock.
REQ-005 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port: req_valid  in  NUM_REQ  per-requester byte-pending flag.
REQ-007 SHALL have port: req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 SHALL have port: req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester.
REQ-009 SHALL have port: tx_data  out  8  byte to the UART byte transmitter.
REQ-010 SHALL have port: tx_start  out  1  one-cycle transmit strobe to the UART byte transmitter.
REQ-011 SHALL have port: tx_done  in  1  one-cycle completion pulse from the UART byte transmitter.
REQ-012 SHALL have port: grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
REQ-013 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port: timeout_err  out  1  one-cycle abort pulse; tied to 0 when UART_ARB_TIMEOUT_EN is not defined.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, WAIT_DONE and GAP.
REQ-016 In IDLE with any req_valid bit set, SHALL select a winner by round-robin, searching upward from pointer rr_ptr with wrap at NUM_REQ.
REQ-017 On the IDLE->GRANT transition, SHALL register tx_data from the winner's req_data, set grant_id to the winner, and assert req_ready[winner] for exactly that one clock edge, so it is visible in GRANT.
REQ-018 SHALL hold tx_start high for exactly one cycle, in GRANT; GRANT SHALL then go unconditionally to WAIT_DONE.
REQ-019 Latency from req_valid rising (FSM in IDLE) to tx_start high SHALL be exactly 1 clock.
REQ-020 SHALL hold tx_data stable from GRANT until the exit from WAIT_DONE.
REQ-021 In WAIT_DONE, tx_done=1 SHALL cause: rr_ptr <= winner+1 modulo NUM_REQ, and the FSM goes to GAP.
REQ-022 tx_done arriving in IDLE, GRANT or GAP SHALL be ignored.
REQ-023 GAP SHALL last exactly GAP_CYCLES clocks, using a 16-bit down-counter, then go to IDLE; with GAP_CYCLES=0, WAIT_DONE SHALL go directly to IDLE.
REQ-024 Requesters SHALL hold req_valid and req_data until their req_ready pulse; deasserting req_valid before the grant drops the request with no error.
REQ-025 A requester whose req_valid stays high SHALL be re-eligible only after all other active requesters have been served once (starvation-free).
REQ-026 When all NUM_REQ requesters are valid simultaneously, grants SHALL be issued in order rr_ptr, rr_ptr+1, ... with wrap-around.

Reset
REQ-027 On rst=1 at a clock edge, SHALL set: state=IDLE, rr_ptr=0, grant_id=0, tx_data=8'h00, tx_start=0, req_ready=0, busy=0, timeout_err=0, gap counter=0.
REQ-028 Reset mid-transfer SHALL abandon the byte without tx_start re-issue; the transmitter is reset by the same rst.

Configuration
REQ-029 Macro UART_ARB_TIMEOUT_EN defined SHALL add a WAIT_DONE watchdog: after TIMEOUT_CYCLES clocks without tx_done, pulse timeout_err for 1 cycle, set rr_ptr <= winner+1, and go to GAP.
REQ-030 Macro UART_ARB_TIMEOUT_EN undefined SHALL make WAIT_DONE wait indefinitely, hold timeout_err constant 0, and include no watchdog counter logic.

Structure
REQ-031 Package uart_arb_pkg SHALL hold the FSM state typedef (2-bit: IDLE, GRANT, WAIT_DONE, GAP) and the constant GAP_CNT_W=16.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs req vector and pointer; outputs winner index and any_valid).

Verification
REQ-033 Reset then req_valid=4'b0001 with byte 8'hA5 -> req_ready[0] and tx_start 1 clock later, tx_data=8'hA5, busy=1 until GAP completes.
REQ-034 req_valid=4'b1111 held, tx_done 50 clocks after each tx_start -> grants 0,1,2,3,0; tx_start spacing = 50+GAP_CYCLES+2 clocks.
REQ-035 After serving requester 2, req_valid=4'b0101 -> next grant is 0, then 2.
REQ-036 tx_done pulsed in IDLE and in GAP -> no state change, no tx_start.
REQ-037 rst asserted in WAIT_DONE -> next cycle all outputs at reset values; a fresh request is granted to requester 0 first.
REQ-038 UART_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, tx_done never pulsed -> timeout_err high for 1 cycle exactly 100 clocks after WAIT_DONE entry, then the next requester is granted.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared FSM state type and counter width for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

  localparam int GAP_CNT_W = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the closest request to ptr is written last and wins.
  always_comb begin
    winner    = ptr;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART byte transmitter from NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog driving timeout_err.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int                   IDX_W    = $clog2(NUM_REQ);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_t           state;
  arb_state_t           state_next;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     ptr_after;
  logic                 any_valid;
  logic                 xfer_end;
  logic [GAP_CNT_W-1:0] gap_cnt;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign ptr_after = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
  assign tx_start  = (state == GRANT);
  assign busy      = (state != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  // A tx_done landing on the final watchdog cycle counts as a normal completion.
  assign wd_expired = (state == WAIT_DONE) && (wd_cnt == WD_LAST) && !tx_done;
  assign xfer_end   = tx_done | wd_expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_expired;
      if (state == WAIT_DONE) wd_cnt <= wd_cnt + 1'b1;
      else                    wd_cnt <= '0;
    end
  end
`else
  // No watchdog: WAIT_DONE never expires, so the abort flag is permanently low.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
  assign xfer_end    = tx_done;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (any_valid) state_next = GRANT;
      GRANT:     state_next = WAIT_DONE;
      WAIT_DONE: if (xfer_end) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       if (gap_cnt <= GAP_CNT_W'(1)) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Byte, grant index and accept pulse are captured on the IDLE->GRANT edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      tx_data   <= 8'h00;
      req_ready <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_next;
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            tx_data           <= req_data[8*int'(winner) +: 8];
            grant_id          <= winner;
            req_ready[winner] <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (xfer_end) begin
            rr_ptr  <= ptr_after;
            gap_cnt <= GAP_LOAD;
          end
        end
        GAP:     gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, fixed sequences, randomized traffic.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int GAP_CYCLES     = 3;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int NUM_VECS       = 26;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        done;
    logic [3:0]  exp_ready;
    logic        exp_start;
    logic [1:0]  exp_gid;
    logic [7:0]  exp_txd;
    logic        exp_busy;
  } vec_t;

  vec_t       vecs[NUM_VECS];
  logic [7:0] cur_byte[NUM_REQ];
  logic [3:0] pend;
  logic [3:0] snap;
  int         checks = 0;
  int         passes = 0;
  int         cyc    = 0;
  int         mptr, served, wait_cnt, delay, cur_w, done_cyc, w, last_start, hits, hit_at;
  bit         in_flight, in_pre, done_now, exp_start, exp_busy, seen;

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic dn);
    req_valid = v;
    req_data  = d;
    tx_done   = dn;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic waitStart(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (tx_start) found = 1'b1;
    end
    checkOutput("start_within_budget", found, 1);
  endtask

  // Reference rule: first valid requester at or after the pointer, wrapping around.
  function automatic int rrPick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [31:0] packData();
    return {cur_byte[3], cur_byte[2], cur_byte[1], cur_byte[0]};
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] bench hung");
  end

  initial begin
    // valid, data, done | ready, start, gid, txd, busy  (GAP_CYCLES = 3)
    vecs[0]  = '{4'b0001, 32'h000000A5, 1'b0, 4'b0001, 1'b1, 2'd0, 8'hA5, 1'b1};
    vecs[1]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA5, 1'b1};
    vecs[2]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA5, 1'b1};
    vecs[3]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA5, 1'b1};
    vecs[4]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA5, 1'b1};
    vecs[5]  = '{4'b0100, 32'h003C0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA5, 1'b1};
    vecs[6]  = '{4'b0100, 32'h003C0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA5, 1'b0};
    vecs[7]  = '{4'b0100, 32'h003C0000, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h3C, 1'b1};
    vecs[8]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h3C, 1'b1};
    vecs[9]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h3C, 1'b1};
    vecs[10] = '{4'b0101, 32'h00220011, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h3C, 1'b1};
    vecs[11] = '{4'b0101, 32'h00220011, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h3C, 1'b1};
    vecs[12] = '{4'b0101, 32'h00220011, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h3C, 1'b0};
    vecs[13] = '{4'b0101, 32'h00220011, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h11, 1'b1};
    vecs[14] = '{4'b0100, 32'h00220000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h11, 1'b1};
    vecs[15] = '{4'b0100, 32'h00220000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h11, 1'b1};
    vecs[16] = '{4'b0100, 32'h00220000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h11, 1'b1};
    vecs[17] = '{4'b0100, 32'h00220000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h11, 1'b1};
    vecs[18] = '{4'b0100, 32'h00220000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h11, 1'b0};
    vecs[19] = '{4'b0100, 32'h00220000, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h22, 1'b1};
    vecs[20] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h22, 1'b1};
    vecs[21] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h22, 1'b1};
    vecs[22] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h22, 1'b1};
    vecs[23] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h22, 1'b1};
    vecs[24] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h22, 1'b0};
    vecs[25] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h22, 1'b0};

    rst = 1'b1;
    applyStimulus(4'b0000, 32'h0, 1'b0);
    repeat (3) tick();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ready", req_ready, 0);
    checkOutput("reset_start", tx_start, 0);
    checkOutput("reset_gid", grant_id, 0);
    checkOutput("reset_txd", tx_data, 0);
    checkOutput("reset_timeout", timeout_err, 0);
    rst = 1'b0;

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].done);
      tick();
      checkOutput($sformatf("vec%0d_ready", i), req_ready, vecs[i].exp_ready);
      checkOutput($sformatf("vec%0d_start", i), tx_start, vecs[i].exp_start);
      checkOutput($sformatf("vec%0d_gid", i), grant_id, vecs[i].exp_gid);
      checkOutput($sformatf("vec%0d_txd", i), tx_data, vecs[i].exp_txd);
      checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
    end

    // Reset while waiting for tx_done; pointer was left at 3 by the table.
    applyStimulus(4'b1000, 32'h77000000, 1'b0);
    tick();
    checkOutput("prerst_start", tx_start, 1);
    checkOutput("prerst_gid", grant_id, 3);
    applyStimulus(4'b0000, 32'h0, 1'b0);
    tick();
    checkOutput("prerst_wait_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", req_ready, 0);
    checkOutput("midrst_start", tx_start, 0);
    checkOutput("midrst_gid", grant_id, 0);
    checkOutput("midrst_txd", tx_data, 0);
    checkOutput("midrst_timeout", timeout_err, 0);
    tick();
    checkOutput("midrst_no_reissue", tx_start, 0);

    // All requesters valid, tx_done 50 clocks after each tx_start.
    for (int i = 0; i < NUM_REQ; i++) cur_byte[i] = 8'(16 * i + 1);
    applyStimulus(4'b1111, packData(), 1'b0);
    tick();
    checkOutput("latency_one_clock", tx_start, 1);
    last_start = cyc;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        waitStart(200, seen);
        checkOutput($sformatf("all_spacing%0d", k), cyc - last_start, 50 + GAP_CYCLES + 2);
        last_start = cyc;
      end
      checkOutput($sformatf("all_gid%0d", k), grant_id, k % NUM_REQ);
      checkOutput($sformatf("all_txd%0d", k), tx_data, cur_byte[k % NUM_REQ]);
      checkOutput($sformatf("all_ready%0d", k), req_ready, 1 << (k % NUM_REQ));
      cur_byte[k % NUM_REQ] = cur_byte[k % NUM_REQ] + 8'h1;
      applyStimulus((k == 4) ? 4'b0000 : 4'b1111, packData(), 1'b0);
      repeat (50) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    repeat (GAP_CYCLES + 2) tick();
    checkOutput("all_idle_after", busy, 0);

    // Randomized traffic against the transaction-level model.
    mptr      = 1;
    pend      = '0;
    in_flight = 1'b0;
    served    = 0;
    wait_cnt  = 0;
    delay     = 0;
    cur_w     = 0;
    done_cyc  = cyc - 100;
    for (int it = 0; it < 4000 && (served < 40 || in_flight); it++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]     = 1'b1;
          cur_byte[i] = 8'($urandom);
        end
      if (in_flight) wait_cnt++;
      done_now = in_flight && (wait_cnt == delay);
      applyStimulus(pend, packData(), done_now);
      snap   = pend;
      in_pre = in_flight;
      tick();
      if (done_now) begin
        in_flight = 1'b0;
        mptr      = (cur_w + 1) % NUM_REQ;
        done_cyc  = cyc;
      end
      exp_start = !in_pre && (cyc - done_cyc >= GAP_CYCLES + 1) && (snap != 4'b0000);
      exp_busy  = in_pre || exp_start || (cyc - done_cyc < GAP_CYCLES);
      checkOutput("rand_start", tx_start, exp_start);
      checkOutput("rand_busy", busy, exp_busy);
      checkOutput("rand_timeout", timeout_err, 0);
      if (tx_start && exp_start) begin
        w = rrPick(snap, mptr);
        checkOutput("rand_gid", grant_id, w);
        checkOutput("rand_txd", tx_data, cur_byte[w]);
        checkOutput("rand_ready", req_ready, 1 << w);
        pend[w]   = 1'b0;
        served++;
        in_flight = 1'b1;
        wait_cnt  = 0;
        delay     = $urandom_range(2, 21);
        cur_w     = w;
      end else begin
        checkOutput("rand_ready_quiet", req_ready, 0);
      end
    end
    checkOutput("rand_completed", (served >= 40) && !in_flight, 1);
    applyStimulus(4'b0000, packData(), 1'b0);
    repeat (GAP_CYCLES + 2) tick();

`ifdef UART_ARB_TIMEOUT_EN
    // No tx_done: watchdog fires 100 clocks after WAIT_DONE entry, then the next requester goes.
    applyStimulus(4'b1111, packData(), 1'b0);
    tick();
    checkOutput("to_start", tx_start, 1);
    checkOutput("to_gid", grant_id, mptr);
    w          = mptr;
    last_start = cyc;
    applyStimulus(4'b1111 & ~(4'b0001 << w), packData(), 1'b0);
    hits   = 0;
    hit_at = -1;
    for (int j = 1; j <= TIMEOUT_CYCLES + 1; j++) begin
      tick();
      if (timeout_err) begin
        hits++;
        hit_at = j;
      end
    end
    checkOutput("to_pulse_at", hit_at, TIMEOUT_CYCLES + 1);
    checkOutput("to_pulse_count", hits, 1);
    tick();
    checkOutput("to_pulse_width", timeout_err, 0);
    waitStart(20, seen);
    checkOutput("to_next_gid", grant_id, (w + 1) % NUM_REQ);
    checkOutput("to_next_spacing", cyc - last_start, TIMEOUT_CYCLES + GAP_CYCLES + 2);
    applyStimulus(4'b0000, packData(), 1'b0);
`endif

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
